// File: rtl/parcare_multi_lane.sv
// Multi-lane parking controller: per-lane barrier FSMs, reservation-based
// capacity control, occupancy counting on confirmed passage, APB config.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   senzor_trecere_i   per-lane pass sensor pulse
//   bariera_o          per-lane barrier raised
//   afisare_locuri_o   OCCUPIED value
//   parcare_full_o     OCCUPIED+PENDING >= CAPACITY (registered)
//   P*                 APB slave (zero wait states)
module parcare_multi_lane #(
  parameter int                 N_LANES     = 2,
  parameter int                 CNT_W       = 8,
  parameter logic [N_LANES-1:0] LANE_DIR    = 'b10,
  parameter int                 TIMEOUT_RST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] senzor_trecere_i,
  output logic [N_LANES-1:0] bariera_o,
  output logic [CNT_W-1:0]   afisare_locuri_o,
  output logic               parcare_full_o,
  input  logic [2:0]         Paddr_i,
  input  logic               Pwrite_i,
  input  logic               Psel_i,
  input  logic               Penable_i,
  input  logic [CNT_W-1:0]   Pwdata_i,
  output logic [CNT_W-1:0]   Prdata_o,
  output logic               Pready_o,
  output logic               Pslverr_o
);

  localparam int W2 = CNT_W + 2;
  localparam logic [W2-1:0] MAXV = {2'b00, {CNT_W{1'b1}}};

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } lane_st_e;

  lane_st_e         st_q  [N_LANES];
  lane_st_e         st_d  [N_LANES];
  logic [CNT_W-1:0] tmr_q [N_LANES];
  logic [CNT_W-1:0] tmr_d [N_LANES];

  logic [CNT_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] rej_q, rej_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] prdata_q;
  logic             full_q;

  logic             setup, access, err, wr_ok;
  logic [N_LANES-1:0] req;
  logic [CNT_W-1:0] tmo_eff;
  logic [CNT_W-1:0] rd_val;
  logic [N_LANES-1:0] bar;

  logic [W2-1:0] base, ngrant, nrej, nep, neto, nxp;
  logic [W2-1:0] osum, rsum, psum;
  logic          full_d;

  // APB decode
  assign setup  = Psel_i & ~Penable_i;
  assign access = Psel_i & Penable_i;
  assign err    = access & ((Paddr_i == 3'd7) |
                  (Pwrite_i & ((Paddr_i == 3'd1) |
                               (Paddr_i == 3'd3) |
                               (Paddr_i == 3'd4))));
  assign wr_ok  = access & Pwrite_i & ~err;
  assign req    = (wr_ok && Paddr_i == 3'd2) ?
                  Pwdata_i[N_LANES-1:0] : '0;

  assign tmo_eff = (tmo_q == '0) ? CNT_W'(1) : tmo_q;
  assign base    = {2'b00, occ_q} + {2'b00, pend_q};

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      bar[i] = (st_q[i] == OPEN);
    end
  end

  // Lane FSMs and grant arbitration, lowest lane index first
  always_comb begin
    ngrant = '0;
    nrej   = '0;
    nep    = '0;
    neto   = '0;
    nxp    = '0;
    for (int i = 0; i < N_LANES; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      if (st_q[i] == OPEN) begin
        if (senzor_trecere_i[i]) begin
          st_d[i] = CLOSED;
          if (LANE_DIR[i]) nxp = nxp + W2'(1);
          else             nep = nep + W2'(1);
        end else if (tmr_q[i] <= CNT_W'(1)) begin
          st_d[i] = CLOSED;
          if (!LANE_DIR[i]) neto = neto + W2'(1);
        end else begin
          tmr_d[i] = tmr_q[i] - CNT_W'(1);
        end
      end else if (req[i]) begin
        if (LANE_DIR[i]) begin
          st_d[i]  = OPEN;
          tmr_d[i] = tmo_eff;
        end else if (base + ngrant < {2'b00, cap_q}) begin
          st_d[i]  = OPEN;
          tmr_d[i] = tmo_eff;
          ngrant   = ngrant + W2'(1);
        end else begin
          nrej = nrej + W2'(1);
        end
      end
    end
  end

  // Counter updates
  always_comb begin
    osum = {2'b00, occ_q} + nep;
    if (osum < nxp)          osum = '0;
    else                     osum = osum - nxp;
    if (osum > MAXV)         osum = MAXV;
    occ_d = osum[CNT_W-1:0];

    psum   = {2'b00, pend_q} + ngrant - nep - neto;
    pend_d = psum[CNT_W-1:0];

    rsum = {2'b00, rej_q} + nrej;
    if (rsum > MAXV) rsum = MAXV;
    rej_d = rsum[CNT_W-1:0];

    cap_d = cap_q;
    tmo_d = tmo_q;
    if (wr_ok) begin
      unique case (Paddr_i)
        3'd0:    cap_d = Pwdata_i;
        3'd5:    rej_d = '0;
        3'd6:    tmo_d = Pwdata_i;
        default: ;
      endcase
    end
  end

  assign full_d = base >= {2'b00, cap_q};

  // Read mux
  always_comb begin
    rd_val = '0;
    unique case (Paddr_i)
      3'd0:    rd_val = cap_q;
      3'd1:    rd_val = occ_q;
      3'd3:    rd_val[N_LANES-1:0] = bar;
      3'd4:    rd_val = pend_q;
      3'd5:    rd_val = rej_q;
      3'd6:    rd_val = tmo_q;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        st_q[i]  <= CLOSED;
        tmr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q    <= '1;
      occ_q    <= '0;
      pend_q   <= '0;
      rej_q    <= '0;
      tmo_q    <= CNT_W'(TIMEOUT_RST);
      prdata_q <= '0;
      full_q   <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      occ_q  <= occ_d;
      pend_q <= pend_d;
      rej_q  <= rej_d;
      tmo_q  <= tmo_d;
      full_q <= full_d;
      if (setup && !Pwrite_i) prdata_q <= rd_val;
    end
  end

  assign bariera_o        = bar;
  assign afisare_locuri_o = occ_q;
  assign parcare_full_o   = full_q;
  assign Prdata_o         = prdata_q;
  assign Pready_o         = access;
  assign Pslverr_o        = err;

endmodule

// File: tb/tb_parcare_multi_lane.sv
// Self-checking bench for parcare_multi_lane (2 lanes: 0 entry, 1 exit).
// APB reads are checked through a scoreboard queue of expected values.
module tb_parcare_multi_lane;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sens = '0;
  logic [1:0] bar;
  logic [7:0] afis;
  logic       full;
  logic [2:0] paddr = '0;
  logic       pwrite = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  parcare_multi_lane #(
    .N_LANES(2), .CNT_W(8), .LANE_DIR(2'b10), .TIMEOUT_RST(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .senzor_trecere_i(sens),
    .bariera_o(bar),
    .afisare_locuri_o(afis),
    .parcare_full_o(full),
    .Paddr_i(paddr),
    .Pwrite_i(pwrite),
    .Psel_i(psel),
    .Penable_i(penable),
    .Pwdata_i(pwdata),
    .Prdata_o(prdata),
    .Pready_o(pready),
    .Pslverr_o(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [2:0] a, input logic [7:0] d,
                        output logic e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_exp(input string tag, input logic [2:0] a,
                        input logic [7:0] exp, input logic exp_err);
    logic [8:0] got;
    logic [8:0] want;
    logic       rdy;
    sb.push_back({exp_err, exp});
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 got = {pslverr, prdata};
    rdy = pready;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    want = sb.pop_front();
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    chk({tag, "_err"}, {31'd0, got[8]}, {31'd0, want[8]});
    if (!want[8]) chk(tag, {24'd0, got[7:0]}, {24'd0, want[7:0]});
  endtask

  task automatic pulse(input logic [1:0] m);
    @(negedge clk);
    sens = m;
    @(negedge clk);
    sens = '0;
  endtask

  logic e;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_bar", {30'd0, bar}, 32'd0);
    chk("rst_afis", {24'd0, afis}, 32'd0);
    chk("rst_prdata", {24'd0, prdata}, 32'd0);
    rst = 1'b0;

    rd_exp("r_cap", 3'd0, 8'd255, 1'b0);
    rd_exp("r_occ", 3'd1, 8'd0, 1'b0);
    rd_exp("r_req", 3'd2, 8'd0, 1'b0);
    rd_exp("r_stat", 3'd3, 8'd0, 1'b0);
    rd_exp("r_pend", 3'd4, 8'd0, 1'b0);
    rd_exp("r_rej", 3'd5, 8'd0, 1'b0);
    rd_exp("r_tmo", 3'd6, 8'd16, 1'b0);
    rd_exp("r_addr7", 3'd7, 8'd0, 1'b1);
    chk("full0", {31'd0, full}, 32'd0);

    // entry with passage
    apb_wr(3'd0, 8'd2, e);
    chk("wcap_err", {31'd0, e}, 32'd0);
    apb_wr(3'd2, 8'h01, e);
    chk("ent_open", {30'd0, bar}, 32'd1);
    rd_exp("ent_pend1", 3'd4, 8'd1, 1'b0);
    rd_exp("ent_stat", 3'd3, 8'd1, 1'b0);
    pulse(2'b01);
    chk("ent_closed", {30'd0, bar}, 32'd0);
    chk("ent_afis", {24'd0, afis}, 32'd1);
    rd_exp("ent_occ", 3'd1, 8'd1, 1'b0);
    rd_exp("ent_pend0", 3'd4, 8'd0, 1'b0);

    // entry timeout
    apb_wr(3'd6, 8'd4, e);
    apb_wr(3'd2, 8'h01, e);
    chk("to_open", {30'd0, bar}, 32'd1);
    repeat (3) @(negedge clk);
    chk("to_still", {30'd0, bar}, 32'd1);
    @(negedge clk);
    chk("to_closed", {30'd0, bar}, 32'd0);
    rd_exp("to_occ", 3'd1, 8'd1, 1'b0);
    rd_exp("to_pend", 3'd4, 8'd0, 1'b0);
    apb_wr(3'd6, 8'd16, e);

    // full, reject, exit
    apb_wr(3'd0, 8'd1, e);
    apb_wr(3'd2, 8'h01, e);
    chk("rej_bar", {30'd0, bar}, 32'd0);
    rd_exp("rej_cnt", 3'd5, 8'd1, 1'b0);
    chk("full1", {31'd0, full}, 32'd1);
    apb_wr(3'd2, 8'h02, e);
    chk("ex_open", {30'd0, bar}, 32'd2);
    pulse(2'b10);
    chk("ex_closed", {30'd0, bar}, 32'd0);
    chk("ex_afis", {24'd0, afis}, 32'd0);
    @(negedge clk);
    chk("full_clr", {31'd0, full}, 32'd0);
    apb_wr(3'd2, 8'h02, e);
    pulse(2'b10);
    chk("ex_sat0", {24'd0, afis}, 32'd0);
    apb_wr(3'd5, 8'h33, e);
    rd_exp("rej_clr", 3'd5, 8'd0, 1'b0);

    // simultaneous entry and exit at OCCUPIED=5
    apb_wr(3'd0, 8'd255, e);
    for (int k = 0; k < 5; k++) begin
      apb_wr(3'd2, 8'h01, e);
      pulse(2'b01);
    end
    chk("occ5", {24'd0, afis}, 32'd5);
    apb_wr(3'd2, 8'h03, e);
    chk("both_open", {30'd0, bar}, 32'd3);
    rd_exp("both_pend", 3'd4, 8'd1, 1'b0);
    pulse(2'b11);
    chk("both_closed", {30'd0, bar}, 32'd0);
    rd_exp("both_occ", 3'd1, 8'd5, 1'b0);
    rd_exp("both_pend0", 3'd4, 8'd0, 1'b0);
    apb_wr(3'd1, 8'd9, e);
    chk("wro_err", {31'd0, e}, 32'd1);
    rd_exp("wro_occ", 3'd1, 8'd5, 1'b0);

    // async reset mid-operation
    apb_wr(3'd2, 8'h01, e);
    chk("mid_open", {30'd0, bar}, 32'd1);
    rd_exp("mid_pend", 3'd4, 8'd1, 1'b0);
    rd_exp("mid_cap", 3'd0, 8'd255, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_bar", {30'd0, bar}, 32'd0);
    chk("arst_afis", {24'd0, afis}, 32'd0);
    chk("arst_full", {31'd0, full}, 32'd0);
    chk("arst_prdata", {24'd0, prdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_exp("arst_cap", 3'd0, 8'd255, 1'b0);
    rd_exp("arst_occ", 3'd1, 8'd0, 1'b0);
    rd_exp("arst_pend", 3'd4, 8'd0, 1'b0);
    rd_exp("arst_tmo", 3'd6, 8'd16, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parcare_multi_lane.md
Name: parcare_multi_lane

Overview:
- Parametrised successor of the single-barrier parking controller: N independent lanes, each with its own barrier FSM and pass sensor; each lane is fixed as entry or exit by parameter.
- Occupancy is counted only on confirmed vehicle passage, not on request.
- Capacity is enforced through a reservation count, so concurrent entry grants never exceed capacity.
- Configured and monitored over APB; drives the barriers, the occupancy display and the full indicator.

Parameters:
N_LANES, 2, number of lanes (1..CNT_W).
CNT_W, 8, width of the occupancy/capacity counters and of the APB data bus (>=8).
LANE_DIR, 'b10, per-lane direction bitmask: bit i=0 entry lane, 1 exit lane.
TIMEOUT_RST, 16, reset value of the TIMEOUT register (cycles a barrier stays open without passage).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
senzor_trecere  in  N_LANES  per-lane pass sensor; single-cycle pulse when a vehicle clears the barrier
bariera  out  N_LANES  1 = barrier of lane i raised
afisare_locuri  out  CNT_W  current OCCUPIED value
parcare_full  out  1  registered; 1 when OCCUPIED+PENDING >= CAPACITY
Paddr  in  3  APB address
Pwrite  in  1  APB write
Psel  in  1  APB select
Penable  in  1  APB enable
Pwdata  in  CNT_W  APB write data
Prdata  out  CNT_W  APB read data
Pready  out  1  APB ready
Pslverr  out  1  APB error

Behaviour:
- Reset (asynchronous, rst=1):
  - bariera=0, afisare_locuri=0, parcare_full=0, Prdata=0.
  - All lane FSMs go to CLOSED.
  - CAPACITY=2^CNT_W-1, OCCUPIED=0, PENDING=0, REJECTS=0, TIMEOUT=TIMEOUT_RST.
  - Reset mid-operation aborts open barriers with no count change.
- APB transfer:
  - Setup phase is Psel & !Penable; access phase is Psel & Penable.
  - Pready = Psel & Penable (zero wait states).
  - Writes commit on the access-phase edge.
  - Prdata is registered on the setup-phase edge and holds until the next read setup.
  - Pslverr = access & (Paddr>6, or write to a read-only register). An erroring write has no effect.
- Register map:
  - 0 CAPACITY rw.
  - 1 OCCUPIED ro.
  - 2 REQ wo: bit i=1 requests lane i; single-cycle pulse, reads 0.
  - 3 STATUS ro: [N_LANES-1:0] = bariera.
  - 4 PENDING ro: entry grants not yet passed.
  - 5 REJECTS rw: saturating count of denied entry requests; any write clears it to 0.
  - 6 TIMEOUT rw: 0 is treated as 1.
- Lane FSM, states CLOSED and OPEN:
  - CLOSED -> OPEN on a granted request. The timer loads TIMEOUT and bariera[i]=1 from the next cycle.
  - OPEN -> CLOSED on senzor_trecere[i] (passage) or when the timer expires (timeout, no count change).
  - Requests to a lane already OPEN are ignored and not counted as rejects.
  - senzor_trecere[i] while CLOSED is ignored.
- Entry grant:
  - Lanes requesting in the same cycle are processed lowest index first.
  - An entry is granted while OCCUPIED+PENDING+grants_so_far < CAPACITY.
  - Each grant does PENDING+1; each denial does REJECTS+1, saturating at 2^CNT_W-1.
- Exit grant: always granted, including when OCCUPIED=0.
- Count updates, applied together in one cycle:
  - Entry passage: PENDING-1, OCCUPIED+1.
  - Entry timeout: PENDING-1.
  - Exit passage: OCCUPIED-1, saturating at 0.
  - Net result = OCCUPIED + entries_passed - exits_passed, clamped to 0..2^CNT_W-1.
- CAPACITY change: lowering CAPACITY below OCCUPIED leaves OCCUPIED untouched. parcare_full stays 1 until OCCUPIED+PENDING < CAPACITY.
- Arithmetic: all sums are computed at CNT_W+2 bits, with no wrap-around.
- Latency:
  - APB REQ write -> bariera high after 1 cycle.
  - Sensor -> bariera low and OCCUPIED update after 1 cycle.
  - parcare_full reflects counters 1 cycle later.

Test Plan:
- Reset, then read addr 0..6 -> 255, 0, 0, 0, 0, 0, 16; Pslverr=0; read addr 7 -> Pslverr=1 in access phase.
- CAPACITY=2; REQ=0b01, then pulse senzor_trecere[0] 3 cycles later -> bariera[0] 1 then 0, OCCUPIED=1, PENDING=0, afisare_locuri=1.
- Entry lane 0 opened with no passage, TIMEOUT=4 -> bariera[0] low after 4 cycles, OCCUPIED unchanged, PENDING back to 0.
- CAPACITY=1, OCCUPIED=1, REQ lane 0 -> no barrier, REJECTS=1, parcare_full=1; exit on lane 1 with passage -> OCCUPIED=0, parcare_full=0.
- Exit passage and entry passage in the same cycle at OCCUPIED=5 -> OCCUPIED=5; write to OCCUPIED -> Pslverr=1, value unchanged.
- Assert rst while bariera[0]=1 and PENDING=1 -> all outputs 0, registers at reset values immediately (asynchronous).
